// File: rtl/decode_pkg.sv
// decode_pkg: opcode and ALU encodings, the decoded control bundle, and the
// decode/operand-usage helpers shared by the decode stage.
package decode_pkg;

  // Opcodes (instruction[INSTR_W-1 -: 3])
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       wb_alu_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic       illegal;
  } ctrl_t;

  // Opcode -> control bundle; opcode 111 behaves as NOP but flags illegal.
  function automatic ctrl_t decode(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP: c = '0;
      OP_ADD: begin
        c.alu_op        = ALU_ADD;
        c.reg_write     = 1'b1;
        c.wb_alu_to_reg = 1'b1;
      end
      OP_SUB: begin
        c.alu_op        = ALU_SUB;
        c.reg_write     = 1'b1;
        c.wb_alu_to_reg = 1'b1;
      end
      OP_AND: begin
        c.alu_op        = ALU_AND;
        c.reg_write     = 1'b1;
        c.wb_alu_to_reg = 1'b1;
      end
      OP_ADDI: begin
        c.alu_op        = ALU_ADD;
        c.alu_src_imm   = 1'b1;
        c.reg_write     = 1'b1;
        c.wb_alu_to_reg = 1'b1;
      end
      OP_LOAD: begin
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_STORE: c.mem_write = 1'b1;
      OP_ILL:   c.illegal   = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Does this opcode actually consume the ra operand?
  function automatic logic reads_ra(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_ADDI) || (op == OP_STORE);
  endfunction

  // Does this opcode actually consume the rb operand?
  function automatic logic reads_rb(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/decode_stage_hs_reg_file.sv
// reg_file_bypass: 2-read / 1-write register file. A write presented in the
// same cycle as a read is forwarded to the read port. Synchronous
// active-low clear of every entry.
// Ports: i_clk, i_rst (active-low sync clear), i_we/i_waddr/i_wdata (write),
//        i_raddr1/i_raddr2 (read addresses), o_rdata1/o_rdata2 (read data).
module reg_file_bypass #(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned N_REGS = 8,
  localparam int unsigned AW     = $clog2(N_REGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr1,
  input  logic [AW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2
);

  logic [WIDTH-1:0] r_mem [N_REGS];

  // Storage update; reset clear beats a concurrent write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read with same-cycle write-back forwarding.
  always_comb begin
    o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
    o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];
  end

endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: instruction decode stage between fetch and execute.
// Decodes one instruction per cycle, reads operands through a bypassed
// register file, and registers controls + operands into ID/EX. Handles the
// valid/ready handshake, load-use bubbles, flush, and counts bubbles.
// Ports: clk, rst (sync active-low); instruction/in_valid/in_ready (fetch
//        side); ex_ready/out_valid + *_r controls/operands (execute side);
//        flush; wb_we/wb_addr/wb_data (write-back); stall_cnt (bubbles).
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned N_REGS  = 8,
  parameter  int unsigned INSTR_W = 16,
  parameter  int unsigned IMM_W   = 10,
  localparam int unsigned AW      = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ex_ready,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  output logic [1:0]         alu_op_r,
  output logic               wb_alu_to_reg_r,
  output logic               reg_write_r,
  output logic               mem_read_r,
  output logic               mem_write_r,
  output logic               alu_src_imm_r,
  output logic [DATA_W-1:0]  rd1_r,
  output logic [DATA_W-1:0]  rd2_r,
  output logic [DATA_W-1:0]  imm_r,
  output logic [AW-1:0]      wr_addr_r,
  output logic               illegal_r,
  output logic [15:0]        stall_cnt
);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Instruction fields
  logic [2:0]        w_op;
  logic [AW-1:0]     w_ra;
  logic [AW-1:0]     w_rb;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_imm_ext;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_hazard;
  logic              w_ex_hold;

  // ID/EX pipeline register
  logic              r_out_valid;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [AW-1:0]     r_wr_addr;
  logic [15:0]       r_stall_cnt;

  always_comb begin
    w_op      = instruction[INSTR_W-1 -: 3];
    w_ra      = instruction[INSTR_W-4 -: AW];
    w_rb      = instruction[INSTR_W-4-AW -: AW];
    w_imm     = instruction[IMM_W-1:0];
    w_imm_ext = DATA_W'($signed(w_imm));
    w_ctrl    = decode(w_op);
  end

  reg_file_bypass #(
    .WIDTH  (DATA_W),
    .N_REGS (N_REGS)
  ) u_rf (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (wb_we),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_ra),
    .i_raddr2 (w_rb),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  // Load-use: only registers the incoming opcode really reads can collide.
  always_comb begin
    w_hazard  = r_out_valid & r_ctrl.mem_read & in_valid &
                ((reads_ra(w_op) & (r_wr_addr == w_ra)) |
                 (reads_rb(w_op) & (r_wr_addr == w_rb)));
    w_ex_hold = r_out_valid & ~ex_ready;
    in_ready  = rst & (flush | (~w_hazard & ~w_ex_hold));
  end

  // ID/EX register and bubble counter, in edge-priority order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_wr_addr   <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
    end else if (!w_ex_hold) begin
      if (w_hazard) begin
        r_out_valid <= 1'b0;
        r_ctrl      <= '0;
        if (r_stall_cnt != STALL_MAX) begin
          r_stall_cnt <= r_stall_cnt + 16'd1;
        end
      end else if (in_valid) begin
        r_out_valid <= 1'b1;
        r_ctrl      <= w_ctrl;
        r_rd1       <= w_rd1;
        r_rd2       <= w_rd2;
        r_imm       <= w_imm_ext;
        r_wr_addr   <= w_ra;
      end else begin
        r_out_valid <= 1'b0;
        r_ctrl      <= '0;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign alu_op_r        = r_ctrl.alu_op;
  assign wb_alu_to_reg_r = r_ctrl.wb_alu_to_reg;
  assign reg_write_r     = r_ctrl.reg_write;
  assign mem_read_r      = r_ctrl.mem_read;
  assign mem_write_r     = r_ctrl.mem_write;
  assign alu_src_imm_r   = r_ctrl.alu_src_imm;
  assign illegal_r       = r_ctrl.illegal;
  assign rd1_r           = r_rd1;
  assign rd2_r           = r_rd2;
  assign imm_r           = r_imm;
  assign wr_addr_r       = r_wr_addr;
  assign stall_cnt       = r_stall_cnt;

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised decode stage: decodes one instruction per cycle, reads/writes a register file with write-back bypass, and registers controls plus operands into the ID/EX pipeline register. Sits between fetch and execute. Adds a valid/ready handshake, load-use hazard detection with bubble insertion, flush, an illegal-opcode flag and a stall counter.

## Interface
- `DATA_W`, 16: register/operand width.
- `N_REGS`, 8: register count; `AW = $clog2(N_REGS)`.
- `INSTR_W`, 16: instruction width; must satisfy `INSTR_W >= 3 + 2*AW`.
- `IMM_W`, 10: immediate width, sign-extended to `DATA_W`; must be `<= DATA_W`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `instruction` in INSTR_W: fields are `op = [INSTR_W-1 -: 3]`, `ra = [INSTR_W-4 -: AW]` (source 1 and destination), `rb = [INSTR_W-4-AW -: AW]`, `imm = [IMM_W-1:0]`.
- `in_valid` in 1: `instruction` is valid.
- `in_ready` out 1: the stage accepts `instruction` this cycle.
- `ex_ready` in 1: execute accepts the ID/EX contents.
- `flush` in 1: drop the current instruction and the ID/EX contents.
- `wb_we` in 1: write-back enable.
- `wb_addr` in AW: write-back register.
- `wb_data` in DATA_W: write-back data.
- `out_valid` out 1: ID/EX holds a valid instruction.
- `alu_op_r` out 2: ALU operation.
- `wb_alu_to_reg_r`, `reg_write_r`, `mem_read_r`, `mem_write_r`, `alu_src_imm_r` out 1 each: registered control signals.
- `rd1_r`, `rd2_r` out DATA_W: operand values read from `ra` and `rb`.
- `imm_r` out DATA_W: sign-extended immediate.
- `wr_addr_r` out AW: destination register (`ra`).
- `illegal_r` out 1: the registered instruction had an illegal opcode.
- `stall_cnt` out 16: number of hazard bubbles inserted; saturating.

## Operation
- Opcode decode; each entry lists controls and registers read:
  - 000 NOP: all controls 0; reads nothing.
  - 001 ADD, 010 SUB, 011 AND: `reg_write = 1`, `wb_alu_to_reg = 1`, `alu_op` = 00/01/10; reads `ra` and `rb`.
  - 100 ADDI: `alu_op = 00`, `alu_src_imm = 1`, `reg_write = 1`, `wb_alu_to_reg = 1`; reads `ra`.
  - 101 LOAD: `mem_read = 1`, `reg_write = 1`, `wb_alu_to_reg = 0`; reads `rb` (address).
  - 110 STORE: `mem_write = 1`; reads `ra` (data) and `rb` (address).
  - 111: illegal; decoded as NOP with `illegal = 1`.
- Register file: writes `wb_data` to `wb_addr` on an edge when `wb_we` is high. All registers are writable and reset to 0.
- Read bypass: if `wb_we` is high and `wb_addr` equals the read address, the read returns `wb_data` in the same cycle.
- Hazard: `hazard = out_valid & mem_read_r & in_valid & (wr_addr_r` matches a register the current instruction reads, per the table above`)`.
- `in_ready = rst & (flush | (~hazard & (~out_valid | ex_ready)))`.
- Per-edge priority (highest first):
  1. `rst` low: clear ID/EX, `stall_cnt` and the register file; all outputs become 0.
  2. `flush`: `out_valid <= 0`; the current instruction is consumed and dropped; no bubble is counted.
  3. `out_valid & ~ex_ready`: ID/EX holds unchanged.
  4. `hazard`: insert a bubble (`out_valid <= 0`, all controls 0, `illegal_r` 0); increment `stall_cnt`, saturating at FFFF; the instruction stays at the input.
  5. `in_valid`: load the decoded instruction; `out_valid <= 1`.
  6. Otherwise: `out_valid <= 0`, controls 0.
- Whenever `out_valid` is 0, all control outputs are 0. Data outputs are don't-care but deterministic.

## Timing
- Latency: 1 cycle from handshake (`in_valid & in_ready`) to `out_valid`.
- A load-use hazard costs exactly 1 bubble. On the next cycle, ID/EX holds the bubble, so the hazard clears.
- A write-back in the same cycle as a read is visible through the bypass. A write-back in an earlier cycle is visible through the register file.
- A flush while execute is stalled still clears ID/EX.
- Reset asserted mid-stall discards everything. `in_ready` is 0 while `rst` is low.
- `rd1_r` and `rd2_r` are captured on the accepting edge and do not track later write-backs while ID/EX holds.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams;
  - the `alu_op` encodings;
  - a packed struct `ctrl_t {alu_op, wb_alu_to_reg, reg_write, mem_read, mem_write, alu_src_imm, illegal}`;
  - a function `decode(op) -> ctrl_t`.
- One sub-module, `reg_file_bypass`, parametrised by `WIDTH` and `N_REGS`: 2 read ports and 1 write port with same-cycle bypass and synchronous active-low clear.
- Hazard logic, handshake logic, the ID/EX register and `stall_cnt` live in the top level.

## Test plan
- Reset, then write-back r3=0x1234, then ADD r3,r3 (`ra = rb = 3`) → next cycle `rd1_r = rd2_r = 0x1234`, `reg_write_r = 1`, `alu_op_r = 00`, `out_valid = 1`.
- LOAD r2 accepted, then ADD r2,r1 presented → one bubble (`out_valid = 0`, `in_ready = 0` for 1 cycle), `stall_cnt = 1`; the ADD then issues.
- `ex_ready = 0` for 3 cycles with ADDI r1 (imm = 0x3FF) in ID/EX → outputs held, `imm_r = 0xFFFF`, `in_ready = 0`; the next instruction issues the cycle after `ex_ready` rises.
- `wb_we = 1`, `wb_addr = 5`, `wb_data = 0xBEEF` in the same cycle an instruction reads r5 → `rd2_r = 0xBEEF`.
- Opcode 111 → `illegal_r = 1` with all controls 0. `flush` during a hazard stall → `out_valid = 0`, the instruction is dropped, `stall_cnt` unchanged.
- `rst` driven low mid-stream for 1 edge → all outputs 0 and a subsequent read of every register returns 0.
